// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencing: BTB prediction and D/E redirect arbitration
// Optional statistics outputs are enabled by defining BTB_STATS_EN.
module fetch_ctrl #(
    parameter int PCW     = 13,
    parameter int ENTRIES = 16
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic [PCW-1:0] f_pc,
    input  logic           stall,
    output logic [PCW-1:0] prepc,
    output logic           hit_predict,
    input  logic           d_redirect,
    input  logic [PCW-1:0] d_target,
    input  logic           e_redirect,
    input  logic [PCW-1:0] e_target,
    output logic           fail_predict,
    output logic [PCW-1:0] nextpc,
    input  logic           upd_valid,
    input  logic [PCW-1:0] upd_pc,
    input  logic [PCW-1:0] upd_target,
    input  logic           upd_taken
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_redirects
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TW   = PCW - IDXW;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [TW-1:0]      tag_d [ENTRIES];
    logic [PCW-1:0]     tgt_q [ENTRIES];
    logic [PCW-1:0]     tgt_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];

    logic               pend_v_q, pend_v_d;
    logic               pend_src_q, pend_src_d;
    logic [PCW-1:0]     pend_pc_q, pend_pc_d;

    logic [IDXW-1:0]    f_idx, u_idx;
    logic [TW-1:0]      f_tag, u_tag;
    logic               upd_hit;

    assign f_idx   = f_pc[IDXW-1:0];
    assign f_tag   = f_pc[PCW-1:IDXW];
    assign u_idx   = upd_pc[IDXW-1:0];
    assign u_tag   = upd_pc[PCW-1:IDXW];
    assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    always_comb begin
        hit_predict = NRST && valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
        prepc       = NRST ? tgt_q[f_idx] : '0;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    tgt_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                tgt_d[u_idx]   = upd_target;
                ctr_d[u_idx]   = 2'b10;
            end
        end
    end

    // The older E request wins; a held E is never displaced by a younger D.
    always_comb begin
        pend_v_d     = pend_v_q;
        pend_src_d   = pend_src_q;
        pend_pc_d    = pend_pc_q;
        fail_predict = 1'b0;
        nextpc       = '0;
        if (NRST) begin
            if (!stall) begin
                pend_v_d = 1'b0;
                if (e_redirect) begin
                    fail_predict = 1'b1;
                    nextpc       = e_target;
                end else if (pend_v_q) begin
                    fail_predict = 1'b1;
                    nextpc       = pend_pc_q;
                end else if (d_redirect) begin
                    fail_predict = 1'b1;
                    nextpc       = d_target;
                end
            end else if (e_redirect) begin
                pend_v_d   = 1'b1;
                pend_src_d = 1'b1;
                pend_pc_d  = e_target;
            end else if (d_redirect && (!pend_v_q || !pend_src_q)) begin
                pend_v_d   = 1'b1;
                pend_src_d = 1'b0;
                pend_pc_d  = d_target;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            valid_q  <= '0;
            pend_v_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            tgt_q      <= tgt_d;
            ctr_q      <= ctr_d;
            pend_v_q   <= pend_v_d;
            pend_src_q <= pend_src_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_redirects_q, stat_redirects_d;

    always_comb begin
        stat_hits_d      = stat_hits_q + {31'd0, (hit_predict && !stall)};
        stat_redirects_d = stat_redirects_q + {31'd0, fail_predict};
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            stat_hits_q      <= '0;
            stat_redirects_q <= '0;
        end else begin
            stat_hits_q      <= stat_hits_d;
            stat_redirects_q <= stat_redirects_d;
        end
    end

    assign stat_hits      = stat_hits_q;
    assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        NRST;
    logic [12:0] f_pc;
    logic        stall;
    logic [12:0] prepc;
    logic        hit_predict;
    logic        d_redirect;
    logic [12:0] d_target;
    logic        e_redirect;
    logic [12:0] e_target;
    logic        fail_predict;
    logic [12:0] nextpc;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic [12:0] upd_target;
    logic        upd_taken;
`ifdef BTB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_redirects;
`endif

    fetch_ctrl dut (
        .CLK          (CLK),
        .NRST         (NRST),
        .f_pc         (f_pc),
        .stall        (stall),
        .prepc        (prepc),
        .hit_predict  (hit_predict),
        .d_redirect   (d_redirect),
        .d_target     (d_target),
        .e_redirect   (e_redirect),
        .e_target     (e_target),
        .fail_predict (fail_predict),
        .nextpc       (nextpc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken)
`ifdef BTB_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_redirects (stat_redirects)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic [12:0] fpc;
        logic        stl;
        logic        dr;
        logic [12:0] dt;
        logic        er;
        logic [12:0] et;
        logic        uv;
        logic [12:0] upc;
        logic [12:0] ut;
        logic        utk;
        logic        exp_hit;
        logic [12:0] exp_prepc;
        logic        exp_fail;
        logic [12:0] exp_nextpc;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic nr, logic [12:0] fp, logic st,
                                logic dr, logic [12:0] dt, logic er, logic [12:0] et,
                                logic uv, logic [12:0] up, logic [12:0] ut, logic tk,
                                logic eh, logic [12:0] ep, logic ef, logic [12:0] en);
        vec_t v;
        v.nrst = nr; v.fpc = fp; v.stl = st;
        v.dr = dr; v.dt = dt; v.er = er; v.et = et;
        v.uv = uv; v.upc = up; v.ut = ut; v.utk = tk;
        v.exp_hit = eh; v.exp_prepc = ep; v.exp_fail = ef; v.exp_nextpc = en;
        return v;
    endfunction

    task automatic chk(input string name, input int step, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%03h expected 0x%03h", name, step, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        NRST = v.nrst; f_pc = v.fpc; stall = v.stl;
        d_redirect = v.dr; d_target = v.dt; e_redirect = v.er; e_target = v.et;
        upd_valid = v.uv; upd_pc = v.upc; upd_target = v.ut; upd_taken = v.utk;
    endtask

    task automatic check_vec(input vec_t v, input int step);
        chk("hit_predict", step, {12'd0, hit_predict}, {12'd0, v.exp_hit});
        chk("fail_predict", step, {12'd0, fail_predict}, {12'd0, v.exp_fail});
        if (v.exp_hit || !v.nrst) chk("prepc", step, prepc, v.exp_prepc);
        if (v.exp_fail || !v.nrst) chk("nextpc", step, nextpc, v.exp_nextpc);
    endtask

    initial begin
        vec_t h;
        //                nr fpc     st dr dt      er et      uv upc     ut      tk  hit prepc   fail nextpc
        vecs[0]  = mk(0, 13'h010, 0, 0, 13'h000, 1, 13'h080, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[1]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[2]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h100, 1, 0, 13'h000, 0, 13'h000);
        vecs[3]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h000, 0, 1, 13'h100, 0, 13'h000);
        vecs[4]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[5]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[6]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h100, 1, 0, 13'h000, 0, 13'h000);
        vecs[7]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h100, 1, 0, 13'h000, 0, 13'h000);
        vecs[8]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h104, 1, 1, 13'h100, 0, 13'h000);
        vecs[9]  = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h104, 1, 1, 13'h104, 0, 13'h000);
        vecs[10] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h104, 1, 1, 13'h104, 0, 13'h000);
        vecs[11] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h000, 0, 1, 13'h104, 0, 13'h000);
        vecs[12] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h000, 0, 1, 13'h104, 0, 13'h000);
        vecs[13] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h010, 13'h100, 1, 0, 13'h000, 0, 13'h000);
        vecs[14] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h030, 13'h200, 1, 1, 13'h100, 0, 13'h000);
        vecs[15] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 1, 13'h055, 13'h300, 0, 0, 13'h000, 0, 13'h000);
        vecs[16] = mk(1, 13'h030, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 1, 13'h200, 0, 13'h000);
        vecs[17] = mk(1, 13'h055, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[18] = mk(1, 13'h000, 0, 1, 13'h040, 1, 13'h080, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h080);
        vecs[19] = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[20] = mk(1, 13'h000, 0, 1, 13'h044, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h044);
        vecs[21] = mk(1, 13'h000, 1, 1, 13'h040, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[22] = mk(1, 13'h000, 1, 0, 13'h000, 1, 13'h080, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[23] = mk(1, 13'h000, 1, 1, 13'h0C0, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[24] = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h080);
        vecs[25] = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[26] = mk(1, 13'h000, 1, 1, 13'h040, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[27] = mk(1, 13'h000, 1, 1, 13'h048, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[28] = mk(1, 13'h000, 0, 1, 13'h050, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h048);
        vecs[29] = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[30] = mk(1, 13'h000, 1, 1, 13'h040, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[31] = mk(1, 13'h000, 0, 0, 13'h000, 1, 13'h090, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h090);
        vecs[32] = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[33] = mk(1, 13'h030, 1, 0, 13'h000, 1, 13'h080, 0, 13'h000, 13'h000, 0, 1, 13'h200, 0, 13'h000);
        vecs[34] = mk(1, 13'h030, 1, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 1, 13'h200, 0, 13'h000);
        vecs[35] = mk(0, 13'h030, 1, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[36] = mk(1, 13'h030, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        vecs[37] = mk(1, 13'h010, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);

        drive(vecs[0]);
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

        // Redirect and BTB allocation in the same cycle, then lookup of the new entry.
        @(negedge CLK);
        h = mk(1, 13'h07A, 0, 0, 13'h000, 1, 13'h0AA, 1, 13'h07A, 13'h1F0, 1, 0, 13'h000, 1, 13'h0AA);
        drive(h);
        #1;
        check_vec(h, 100);
        @(negedge CLK);
        h = mk(1, 13'h07A, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 1, 13'h1F0, 0, 13'h000);
        drive(h);
        #1;
        check_vec(h, 101);

        // Stalled E survives several stall cycles and a later D, then is delivered once.
        @(negedge CLK);
        h = mk(1, 13'h000, 1, 1, 13'h020, 1, 13'h0F0, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        drive(h);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            h = mk(1, 13'h000, 1, 1, 13'h024, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
            drive(h);
            #1;
            check_vec(h, 102 + k);
        end
        @(negedge CLK);
        h = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 1, 13'h0F0);
        drive(h);
        #1;
        check_vec(h, 105);
        @(negedge CLK);
        h = mk(1, 13'h000, 0, 0, 13'h000, 0, 13'h000, 0, 13'h000, 13'h000, 0, 0, 13'h000, 0, 13'h000);
        drive(h);
        #1;
        check_vec(h, 106);

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
